// File: rtl/render_datapath.sv
// Instruction datapath: executes one pixel/memory instruction per start/finished handshake
// against an internal scratch RAM and framebuffer, and drives the VGA pixel-plot interface.
module render_datapath #(
    parameter int unsigned SCREEN_WIDTH      = 160,
    parameter int unsigned SCREEN_HEIGHT     = 120,
    parameter int unsigned X_WIDTH           = 8,
    parameter int unsigned Y_WIDTH           = 7,
    parameter int unsigned COLOUR_WIDTH      = 3,
    parameter int unsigned FB_ADDR_WIDTH     = 15,
    parameter int unsigned MEM_ADDR_WIDTH    = 12,
    parameter int unsigned MEM_DATA_WIDTH    = 16,
    parameter int unsigned OPCODE_WIDTH      = 4,
    parameter int unsigned INSTRUCTION_WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [MEM_DATA_WIDTH-1:0]    result,
    output logic [X_WIDTH-1:0]           x,
    output logic [Y_WIDTH-1:0]           y,
    output logic [COLOUR_WIDTH-1:0]      colour,
    output logic                         plot,
    output logic                         finished,
    output logic                         error
);

    localparam logic [OPCODE_WIDTH-1:0] OpNop      = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OpDraw     = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OpMemRead  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OpMemWrite = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OpDisplay  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OpClear    = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OpScan     = OPCODE_WIDTH'(6);

    typedef enum logic [2:0] {
        StIdle, StWrite, StRead, StWait, StClear, StScanPre, StScan, StFin
    } state_e;

    state_e                         state_q;
    logic [INSTRUCTION_WIDTH-1:0]   instr_q;
    logic [X_WIDTH-1:0]             cnt_x_q;
    logic [Y_WIDTH-1:0]             cnt_y_q;
    logic                           scan_vld_q;
    logic [X_WIDTH-1:0]             scan_x_q;
    logic [Y_WIDTH-1:0]             scan_y_q;

    logic [OPCODE_WIDTH-1:0]        opcode;
    logic [OPCODE_WIDTH-1:0]        start_op;
    logic [X_WIDTH-1:0]             pix_x;
    logic [Y_WIDTH-1:0]             pix_y;
    logic [COLOUR_WIDTH-1:0]        pix_c;
    logic [MEM_ADDR_WIDTH-1:0]      mem_addr;
    logic [MEM_DATA_WIDTH-1:0]      mem_wdata;
    logic                           in_range;
    logic                           illegal;
    logic                           pixel_op;
    logic                           cnt_last_x;
    logic                           cnt_last_y;
    logic [FB_ADDR_WIDTH-1:0]       pix_addr;
    logic [FB_ADDR_WIDTH-1:0]       cnt_addr;
    logic [FB_ADDR_WIDTH-1:0]       fb_addr;
    logic                           fb_we;
    logic                           mem_we;
    logic [COLOUR_WIDTH-1:0]        fb_rdata;
    logic [MEM_DATA_WIDTH-1:0]      mem_rdata;
    state_e                         start_state;

    logic [COLOUR_WIDTH-1:0]   fb_mem  [2**FB_ADDR_WIDTH];
    logic [MEM_DATA_WIDTH-1:0] ram_mem [2**MEM_ADDR_WIDTH];

    assign opcode    = instr_q[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
    assign start_op  = instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
    assign pix_x     = instr_q[X_WIDTH-1:0];
    assign pix_y     = instr_q[X_WIDTH +: Y_WIDTH];
    assign pix_c     = instr_q[X_WIDTH+Y_WIDTH +: COLOUR_WIDTH];
    assign mem_addr  = instr_q[MEM_ADDR_WIDTH-1:0];
    assign mem_wdata = instr_q[MEM_ADDR_WIDTH +: MEM_DATA_WIDTH];

    assign in_range   = (32'(pix_x) < SCREEN_WIDTH) && (32'(pix_y) < SCREEN_HEIGHT);
    assign illegal    = opcode > OpScan;
    assign pixel_op   = (opcode == OpDraw) || (opcode == OpDisplay);
    assign cnt_last_x = cnt_x_q == X_WIDTH'(SCREEN_WIDTH - 1);
    assign cnt_last_y = cnt_y_q == Y_WIDTH'(SCREEN_HEIGHT - 1);

    assign pix_addr = FB_ADDR_WIDTH'(pix_y) * FB_ADDR_WIDTH'(SCREEN_WIDTH)
                    + FB_ADDR_WIDTH'(pix_x);
    assign cnt_addr = FB_ADDR_WIDTH'(cnt_y_q) * FB_ADDR_WIDTH'(SCREEN_WIDTH)
                    + FB_ADDR_WIDTH'(cnt_x_q);

    // Write enables are decoded from state so an asynchronous reset kills them at once.
    assign fb_addr = (state_q == StClear || state_q == StScan) ? cnt_addr : pix_addr;
    assign fb_we   = (state_q == StClear)
                  || (state_q == StWrite && opcode == OpDraw && in_range);
    assign mem_we  = (state_q == StWrite) && (opcode == OpMemWrite);

    always_comb begin
        start_state = StFin;
        unique case (start_op)
            OpDraw, OpMemWrite:  start_state = StWrite;
            OpMemRead, OpDisplay: start_state = StRead;
            OpClear:             start_state = StClear;
            OpScan:              start_state = StScanPre;
            default:             start_state = StFin;
        endcase
    end

    always_ff @(posedge clock) begin
        if (fb_we) begin
            fb_mem[fb_addr] <= pix_c;
        end
        fb_rdata <= fb_mem[fb_addr];
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            ram_mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram_mem[mem_addr];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            instr_q    <= '0;
            cnt_x_q    <= '0;
            cnt_y_q    <= '0;
            scan_vld_q <= 1'b0;
            scan_x_q   <= '0;
            scan_y_q   <= '0;
            result     <= '0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            finished   <= 1'b1;
            error      <= 1'b0;
        end else begin
            plot       <= 1'b0;
            scan_vld_q <= 1'b0;
            // Scan pipeline: address cycle, then RAM data cycle, then the plot pulse.
            if (scan_vld_q) begin
                plot   <= 1'b1;
                x      <= scan_x_q;
                y      <= scan_y_q;
                colour <= fb_rdata;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        instr_q  <= instruction;
                        error    <= 1'b0;
                        finished <= 1'b0;
                        cnt_x_q  <= '0;
                        cnt_y_q  <= '0;
                        state_q  <= start_state;
                    end
                end
                StWrite:   state_q <= StFin;
                StRead:    state_q <= StWait;
                StWait:    state_q <= StFin;
                StScanPre: state_q <= StScan;
                StClear, StScan: begin
                    if (state_q == StScan) begin
                        scan_vld_q <= 1'b1;
                        scan_x_q   <= cnt_x_q;
                        scan_y_q   <= cnt_y_q;
                    end
                    if (cnt_last_x) begin
                        cnt_x_q <= '0;
                        if (cnt_last_y) begin
                            state_q <= StFin;
                        end else begin
                            cnt_y_q <= cnt_y_q + 1'b1;
                        end
                    end else begin
                        cnt_x_q <= cnt_x_q + 1'b1;
                    end
                end
                StFin: begin
                    finished <= 1'b1;
                    state_q  <= StIdle;
                    error    <= illegal || (pixel_op && !in_range);
                    if (opcode == OpMemRead) begin
                        result <= mem_rdata;
                    end
                    if (opcode == OpDisplay && in_range) begin
                        plot   <= 1'b1;
                        x      <= pix_x;
                        y      <= pix_y;
                        colour <= fb_rdata;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_render_datapath.sv
// Scoreboard bench for render_datapath: a default-geometry instance driven through a
// reference model, plus a 4x3 instance for a short raster-scan check.
module tb_render_datapath;

    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] instruction;
    logic [15:0] result;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, finished, error;

    logic        s_start;
    logic [31:0] s_instruction;
    logic [15:0] s_result;
    logic [7:0]  s_x;
    logic [6:0]  s_y;
    logic [2:0]  s_colour;
    logic        s_plot, s_finished, s_error;

    always #5 clock = ~clock;

    render_datapath u_dut (
        .clock(clock), .reset(reset), .start(start), .instruction(instruction),
        .result(result), .x(x), .y(y), .colour(colour), .plot(plot),
        .finished(finished), .error(error)
    );

    render_datapath #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(3)) u_small (
        .clock(clock), .reset(reset), .start(s_start), .instruction(s_instruction),
        .result(s_result), .x(s_x), .y(s_y), .colour(s_colour), .plot(s_plot),
        .finished(s_finished), .error(s_error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        int          lat;
        logic [15:0] res;
        bit          err;
        int          npix;
    } exp_t;

    exp_t        exp_q[$];
    logic [17:0] pix_q[$];
    logic [2:0]  mfb  [N];
    logic [15:0] mmem [4096];
    logic [15:0] m_res = '0;

    function automatic logic [31:0] mk_pix(input int op, input int px, input int py,
                                           input int pc);
        logic [3:0] o = 4'(op);
        logic [7:0] xx = 8'(px);
        logic [6:0] yy = 7'(py);
        logic [2:0] cc = 3'(pc);
        return {o, 10'b0, cc, yy, xx};
    endfunction

    function automatic logic [31:0] mk_mem(input int op, input int addr, input int data);
        logic [3:0]  o = 4'(op);
        logic [11:0] a = 12'(addr);
        logic [15:0] d = 16'(data);
        return {o, d, a};
    endfunction

    // Reference model: computes latency, error, result and plotted pixels per instruction.
    task automatic model(input logic [31:0] ins);
        exp_t e;
        int   op = int'(ins[31:28]);
        int   px = int'(ins[7:0]);
        int   py = int'(ins[14:8]);
        int   pa = int'(ins[11:0]);
        bit   inr = (px < W) && (py < H);
        e.err = 1'b0;
        e.npix = 0;
        case (op)
            0: e.lat = 1;
            1: begin
                e.lat = 2;
                e.err = !inr;
                if (inr) mfb[py * W + px] = ins[17:15];
            end
            2: begin
                e.lat = 3;
                m_res = mmem[pa];
            end
            3: begin
                e.lat = 2;
                mmem[pa] = ins[27:12];
            end
            4: begin
                e.lat = 3;
                e.err = !inr;
                if (inr) begin
                    pix_q.push_back({ins[7:0], ins[14:8], mfb[py * W + px]});
                    e.npix = 1;
                end
            end
            5: begin
                e.lat = N + 1;
                for (int i = 0; i < N; i++) mfb[i] = ins[17:15];
            end
            6: begin
                e.lat = N + 2;
                e.npix = N;
                for (int i = 0; i < N; i++) pix_q.push_back({8'(i % W), 7'(i / W), mfb[i]});
            end
            default: begin
                e.lat = 1;
                e.err = 1'b1;
            end
        endcase
        e.res = m_res;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!finished && t < 50000) begin
            @(negedge clock);
            t++;
        end
        if (!finished) check_eq("wait_finished_timeout", 64'(finished), 64'd1);
    endtask

    task automatic issue(input logic [31:0] ins, input bit track);
        wait_idle();
        instruction = ins;
        start = 1'b1;
        if (track) model(ins);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic s_issue(input logic [31:0] ins);
        int t = 0;
        while (!s_finished && t < 100) begin
            @(negedge clock);
            t++;
        end
        s_instruction = ins;
        s_start = 1'b1;
        @(negedge clock);
        s_start = 1'b0;
    endtask

    int busy = 0;
    int pulses = 0;
    bit prev_fin = 1'b1;

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            busy = 0;
            pulses = 0;
            prev_fin = 1'b1;
        end else begin
            if (plot) begin
                pulses++;
                if (pix_q.size() == 0) check_eq("unexpected_plot", 64'(plot), 64'd0);
                else check_eq("plot_pixel", 64'({x, y, colour}), 64'(pix_q.pop_front()));
            end
            if (!finished) busy++;
            if (finished && !prev_fin) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_finish", 64'(finished), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("latency", 64'(busy), 64'(e.lat));
                    check_eq("error", 64'(error), 64'(e.err));
                    check_eq("result", 64'(result), 64'(e.res));
                    check_eq("plot_count", 64'(pulses), 64'(e.npix));
                end
                busy = 0;
                pulses = 0;
            end
            prev_fin = finished;
        end
    end

    initial begin
        int          t;
        int          np;
        int          sbusy;
        int          first;
        bit          done;
        logic [7:0]  ex;
        logic [6:0]  ey;
        logic [2:0]  ec;

        reset = 1'b1;
        start = 1'b0;
        instruction = '0;
        s_start = 1'b0;
        s_instruction = '0;
        @(negedge clock);
        @(negedge clock);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_x", 64'(x), 64'd0);
        check_eq("rst_y", 64'(y), 64'd0);
        check_eq("rst_colour", 64'(colour), 64'd0);
        check_eq("rst_plot", 64'(plot), 64'd0);
        check_eq("rst_finished", 64'(finished), 64'd1);
        check_eq("rst_error", 64'(error), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Abort a CLEAR after its first nine writes with an asynchronous reset.
        issue(mk_pix(5, 0, 0, 4), 1'b0);
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_eq("abort_finished", 64'(finished), 64'd1);
        check_eq("abort_plot", 64'(plot), 64'd0);
        check_eq("abort_error", 64'(error), 64'd0);
        for (int i = 0; i < 9; i++) mfb[i] = 3'd4;
        m_res = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        issue(mk_pix(4, 0, 0, 0), 1'b1);

        issue(mk_pix(5, 0, 0, 3), 1'b1);
        issue(mk_mem(3, 'h0A5, 'hBEEF), 1'b1);
        issue(mk_mem(2, 'h0A5, 0), 1'b1);
        issue(mk_mem(3, 'h0A6, 'h1234), 1'b1);
        issue(mk_pix(0, 0, 0, 0), 1'b1);
        issue(mk_mem(2, 'h0A6, 0), 1'b1);
        issue(mk_pix(1, 159, 119, 5), 1'b1);
        issue(mk_pix(4, 159, 119, 0), 1'b1);
        issue(mk_pix(1, 0, 0, 1), 1'b1);
        issue(mk_pix(1, W - 1, 0, 2), 1'b1);
        issue(mk_pix(1, 0, H - 1, 6), 1'b1);
        issue(mk_pix(1, 160, 0, 6), 1'b1);
        issue(mk_pix(4, 0, 120, 0), 1'b1);
        issue(mk_pix(0, 0, 0, 0), 1'b1);
        issue(mk_pix(4, 0, 0, 0), 1'b1);

        // Illegal opcode with start held across four edges: accepted twice.
        wait_idle();
        instruction = {4'hF, 28'h0};
        start = 1'b1;
        model(instruction);
        model(instruction);
        repeat (4) @(negedge clock);
        start = 1'b0;

        issue(mk_pix(1, 1, 1, 7), 1'b1);
        issue(mk_pix(4, 1, 1, 0), 1'b1);
        issue(mk_pix(6, 0, 0, 0), 1'b1);
        t = 0;
        while (exp_q.size() != 0 && t < 50000) begin
            @(negedge clock);
            t++;
        end
        check_eq("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        check_eq("pix_queue_drained", 64'(pix_q.size()), 64'd0);

        // 4x3 screen: CLEAR 2, DRAW (1,1)=7, then SCAN.
        s_issue(mk_pix(5, 0, 0, 2));
        s_issue(mk_pix(1, 1, 1, 7));
        s_issue(mk_pix(6, 0, 0, 0));
        np = 0;
        sbusy = 0;
        first = -1;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (s_plot) begin
                ex = 8'(np % 4);
                ey = 7'(np / 4);
                ec = (ex == 8'd1 && ey == 7'd1) ? 3'd7 : 3'd2;
                check_eq("small_scan_pixel", 64'({s_x, s_y, s_colour}), 64'({ex, ey, ec}));
                if (first < 0) first = k;
                check_eq("small_scan_consecutive", 64'(k - first), 64'(np));
                np++;
            end
            if (s_finished) done = 1'b1;
            else begin
                sbusy++;
                @(negedge clock);
            end
        end
        check_eq("small_scan_done", 64'(done), 64'd1);
        check_eq("small_scan_latency", 64'(sbusy), 64'd14);
        check_eq("small_scan_pulses", 64'(np), 64'd12);
        @(negedge clock);
        check_eq("small_plot_after", 64'(s_plot), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
